// File: rtl/rf_writeback.sv
// -----------------------------------------------------------------------------
// rf_writeback
//
// Owns the single write port of the integer register file. Single-cycle ALU
// results and multi-cycle load results are merged here: ALU results always win
// the port, while load results are parked in a small in-order FIFO and retired
// whenever the ALU leaves the port idle. The port itself (we3/a3/wd3) is driven
// straight from flops.
//
// A 32-bit scoreboard (pend) tracks registers that have an outstanding load so
// decode can stall on RAW/WAW hazards. A bit is set when the load is issued and
// cleared on the same edge that the register file captures the load data.
//
// Parameters
//   XLEN        datapath width
//   FIFO_DEPTH  load-result buffer entries (power of two, >= 2)
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   alu_valid    ALU result present this cycle (never back-pressured)
//   alu_rd       ALU destination register
//   alu_data     ALU result
//   mem_valid    load result offered
//   mem_ready    load result accepted when mem_valid && mem_ready
//   mem_rd       load destination register
//   mem_data     load data
//   issue_valid  a load is issued this cycle
//   issue_rd     destination of the issued load
//   pend         scoreboard, bit i set while a load to xi is outstanding
//   we3          register-file write enable (registered)
//   a3           register-file write address (registered)
//   wd3          register-file write data (registered)
// -----------------------------------------------------------------------------
module rf_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     pend,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3
);

  // FIFO_DEPTH is a power of two, so a plain PTR_W-bit increment wraps
  // modulo the depth. The counter needs one extra bit to represent "full".
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Load-result FIFO state
  // ---------------------------------------------------------------------------
  logic [4:0]       fifo_rd_r   [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [4:0]       head_rd_s;
  logic [XLEN-1:0]  head_data_s;

  // ---------------------------------------------------------------------------
  // Write-port and scoreboard state
  // ---------------------------------------------------------------------------
  logic             alu_win_s;
  logic             we3_nxt_s;
  logic [4:0]       a3_nxt_s;
  logic [XLEN-1:0]  wd3_nxt_s;
  logic             wb_mem_r;
  logic             wb_mem_nxt_s;

  logic [31:0]      pend_r;
  logic [31:0]      pend_nxt_s;
  logic [31:0]      set_mask_s;
  logic [31:0]      clr_mask_s;

  // Full/empty come only from registered occupancy, so mem_ready never
  // depends on a same-cycle pop and a full FIFO refuses every offer.
  assign full_s      = (count_r == CNT_FULL);
  assign empty_s     = (count_r == CNT_ZERO);
  assign mem_ready   = !full_s;
  assign push_s      = mem_valid && !full_s;
  assign head_rd_s   = fifo_rd_r[rd_ptr_r];
  assign head_data_s = fifo_data_r[rd_ptr_r];

  // x0 writes from the ALU are meaningless, so they neither use the port
  // nor hold off a FIFO pop.
  assign alu_win_s = alu_valid && (alu_rd != 5'd0);

  // The FIFO head is popped whenever the ALU does not own the port. A head
  // pushed this cycle is not visible yet because count_r is still zero.
  assign pop_s = !alu_win_s && !empty_s;

  assign pend = pend_r;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage: written at the write pointer on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_rd_r[wr_ptr_r]   <= mem_rd;
        fifo_data_r[wr_ptr_r] <= mem_data;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Write-port arbitration: ALU first, then the FIFO head, else idle with
  // address/data held so the register-file inputs do not toggle needlessly.
  always_comb begin
    we3_nxt_s    = 1'b0;
    a3_nxt_s     = a3;
    wd3_nxt_s    = wd3;
    wb_mem_nxt_s = 1'b0;
    if (alu_win_s) begin
      we3_nxt_s    = 1'b1;
      a3_nxt_s     = alu_rd;
      wd3_nxt_s    = alu_data;
      wb_mem_nxt_s = 1'b0;
    end else if (!empty_s) begin
      // A head addressed to x0 is still popped, just never written.
      we3_nxt_s    = (head_rd_s != 5'd0);
      a3_nxt_s     = head_rd_s;
      wd3_nxt_s    = head_data_s;
      wb_mem_nxt_s = 1'b1;
    end else begin
      we3_nxt_s    = 1'b0;
      a3_nxt_s     = a3;
      wd3_nxt_s    = wd3;
      wb_mem_nxt_s = 1'b0;
    end
  end

  // Registered write port plus the flag marking a load-sourced write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3      <= 1'b0;
      a3       <= 5'd0;
      wd3      <= {XLEN{1'b0}};
      wb_mem_r <= 1'b0;
    end else begin
      we3      <= we3_nxt_s;
      a3       <= a3_nxt_s;
      wd3      <= wd3_nxt_s;
      wb_mem_r <= wb_mem_nxt_s;
    end
  end

  // Scoreboard update. The clear fires on the edge that ends a load write
  // cycle, i.e. the same edge the register file captures the value, so a
  // dropped pend bit always means the data is already readable. A new issue
  // to the same register on that edge must win, hence set is applied last.
  always_comb begin
    if (we3 && wb_mem_r) begin
      clr_mask_s = 32'd1 << a3;
    end else begin
      clr_mask_s = 32'd0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      set_mask_s = 32'd1 << issue_rd;
    end else begin
      set_mask_s = 32'd0;
    end
    // x0 is hardwired to zero and can never be pending.
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= 32'd0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     pend;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;

  int checks = 0;
  int errors = 0;

  // expected load writes {rd, data}, in retirement order
  logic [36:0] mem_q[$];

  rf_writeback #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .pend       (pend),
    .we3        (we3),
    .a3         (a3),
    .wd3        (wd3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_data    = 32'd0;
    mem_valid   = 1'b0;
    mem_rd      = 5'd0;
    mem_data    = 32'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
  endtask

  // Advance one cycle and check the write port against the scoreboard.
  task automatic step();
    logic        alu_fire;
    logic [36:0] alu_exp;
    logic [36:0] e;
    alu_fire = alu_valid && (alu_rd != 5'd0);
    alu_exp  = {alu_rd, alu_data};
    if (mem_valid && mem_ready && (mem_rd != 5'd0))
      mem_q.push_back({mem_rd, mem_data});
    @(posedge clk);
    #1;
    if (alu_fire) begin
      chk("alu_write", {27'd0, we3, a3, wd3}, {27'd0, 1'b1, alu_exp});
    end else if (we3 && (mem_q.size() > 0)) begin
      e = mem_q.pop_front();
      chk("load_write", {27'd0, we3, a3, wd3}, {27'd0, 1'b1, e});
    end else if (mem_q.size() == 0) begin
      chk("no_write", {63'd0, we3}, 64'd0);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_we3", {63'd0, we3}, 64'd0);
    chk("rst_a3", {59'd0, a3}, 64'd0);
    chk("rst_wd3", {32'd0, wd3}, 64'd0);
    chk("rst_pend", {32'd0, pend}, 64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write to x5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("t1_we3_high", {63'd0, we3}, 64'd1);
    idle();
    step();
    chk("t1_we3_low", {63'd0, we3}, 64'd0);

    // Issue x7, load returns two cycles later
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    chk("t2_pend_set", {63'd0, pend[7]}, 64'd1);
    idle();
    step();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h12345678;
    step();                       // handshake edge
    idle();
    chk("t2_pend_hold1", {63'd0, pend[7]}, 64'd1);
    step();                       // pop edge
    chk("t2_we3_load", {63'd0, we3}, 64'd1);
    chk("t2_pend_hold2", {63'd0, pend[7]}, 64'd1);
    step();                       // commit edge
    chk("t2_pend_clr", {63'd0, pend[7]}, 64'd0);

    // ALU hogs x1 for 4 cycles while loads x2,x3,x4 arrive
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + i;
      mem_valid = 1'b1;
      mem_rd    = (i == 0) ? 5'd2 : (i == 1) ? 5'd3 : 5'd4;
      mem_data  = 32'hA000 + {27'd0, mem_rd};
      chk("t3_ready_fill", {63'd0, mem_ready}, (i < 2) ? 64'd1 : 64'd0);
      step();
    end
    alu_valid = 1'b0; alu_rd = 5'd0;
    chk("t3_ready_full", {63'd0, mem_ready}, 64'd0);
    step();
    chk("t3_ready_free", {63'd0, mem_ready}, 64'd1);
    step();
    idle();
    step();
    step();
    step();
    chk("t3_drained", mem_q.size(), 64'd0);

    // x0 traffic: loads to x0 drain even while alu_valid with rd=0
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h200 + i;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBAD0 + i;
      step();
    end
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD9;
    issue_valid = 1'b1; issue_rd = 5'd0;
    chk("t4_full", {63'd0, mem_ready}, 64'd0);
    step();
    issue_valid = 1'b0;
    step();
    idle();
    chk("t4_drained", {63'd0, mem_ready}, 64'd1);
    step();
    chk("t4_pend0", {32'd0, pend}, 64'd0);

    // Re-issue of x9 on the edge its previous load commits
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    idle();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99999999;
    step();                       // handshake
    idle();
    step();                       // pop
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();                       // commit + re-issue
    idle();
    chk("t5_pend_set_wins", {63'd0, pend[9]}, 64'd1);

    // Fill FIFO, then asynchronous reset mid-cycle
    issue_valid = 1'b1; issue_rd = 5'd10;
    step();
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h300 + i;
      mem_valid = 1'b1; mem_rd = 5'd10 + i[4:0]; mem_data = 32'hC000 + i;
      issue_valid = 1'b0;
      step();
    end
    idle();
    chk("t6_full", {63'd0, mem_ready}, 64'd0);
    chk("t6_pend10", {63'd0, pend[10]}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we3", {63'd0, we3}, 64'd0);
    chk("t6_rst_pend", {32'd0, pend}, 64'd0);
    chk("t6_rst_ready", {63'd0, mem_ready}, 64'd1);
    mem_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t6_no_stale_pend", {32'd0, pend}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback unit that owns the write port of the integer register file. It merges single-cycle ALU results with multi-cycle load results, buffers loads in a small FIFO, and drives `we3`/`a3`/`wd3` from registers. It also keeps a 32-bit scoreboard of registers awaiting a load so that decode can stall on RAW/WAW hazards. It sits between execute/memory and the register file.

## Interface
- `XLEN`, 32, datapath width
- `FIFO_DEPTH`, 2, load-result buffer entries; power of two, at least 2

- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no backpressure
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `mem_valid`  in  1  load result offered
- `mem_ready`  out  1  load result accepted when `mem_valid && mem_ready`
- `mem_rd`  in  5  load destination register
- `mem_data`  in  XLEN  load data
- `issue_valid`  in  1  a load is issued this cycle; marks `issue_rd` pending
- `issue_rd`  in  5  destination of the issued load
- `pend`  out  32  scoreboard; bit i=1 means a load to xi is outstanding; bit 0 is always 0
- `we3`  out  1  register-file write enable (registered)
- `a3`  out  5  register-file write address (registered)
- `wd3`  out  XLEN  register-file write data (registered)

## Operation
- Reset (`rst_n`=0, asynchronous): `we3`=0, `a3`=0, `wd3`=0, `pend`=0, FIFO empty, pointers 0. `mem_ready` is 1 out of reset.
- FIFO:
  - Push on `mem_valid && mem_ready`.
  - `mem_ready = !full`, combinational from registered occupancy only. It has no dependence on a same-cycle pop; a full FIFO never accepts.
  - Pointer wrap is modulo `FIFO_DEPTH`. Occupancy counter width is log2(`FIFO_DEPTH`)+1.
  - A push to an empty FIFO is not bypassed. The entry becomes poppable the following cycle.
- Write-port arbitration, evaluated each cycle and registered at the edge:
  - `alu_valid && alu_rd!=0`: next `we3`=1, `a3`=`alu_rd`, `wd3`=`alu_data`. Any FIFO head waits.
  - Otherwise, if the FIFO is not empty: pop the head. Next `we3`=(head rd!=0), `a3`=head rd, `wd3`=head data. A head with rd=0 is popped and discarded.
  - Otherwise: next `we3`=0. `a3`/`wd3` hold their previous values.
  - `alu_valid` with `alu_rd`=0 is ignored and does not block a pop.
- Internal `wb_mem` flag, registered with `we3`: set when the current write came from the FIFO.
- Scoreboard:
  - Set: bit `issue_rd` is set at the edge when `issue_valid && issue_rd!=0`.
  - Clear: bit `a3` is cleared at the edge ending a cycle with `we3 && wb_mem`, i.e. the same edge the register file captures the data. `pend` therefore drops only when the register file already holds the new value.
  - Set and clear on the same bit at the same edge: set wins.
  - ALU writes never clear `pend`. Decode guarantees no ALU write targets a pending register.

## Timing
- ALU path: `alu_valid` in cycle N → `we3`=1 in cycle N+1 → register file updated at the end of N+1.
- Load path with no ALU contention: handshake in cycle N → pop in N+1 → `we3`=1 in N+2 → `pend` bit low in N+3.
- Sustained throughput is one register write per cycle. Loads can starve while `alu_valid` is asserted every cycle; back-pressure reaches memory through `mem_ready`.
- FIFO entries retire strictly in order.
- Reset asserted mid-operation discards all buffered loads and pending bits immediately, with no partial write. `we3` drops asynchronously.

## Test plan
- Reset, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF for one cycle → next cycle `we3`=1, `a3`=5, `wd3`=0xDEADBEEF; the cycle after, `we3`=0.
- `issue_rd`=7, then load handshake rd=7, data=0x12345678 two cycles later with no ALU traffic → `pend[7]`=1 from the issue edge; `we3`/`a3`=7/`wd3`=0x12345678 two cycles after the handshake; `pend[7]`=0 one cycle later.
- Keep `alu_valid`=1 to x1 for 4 cycles while pushing loads to x2, x3, x4 → third push refused (`mem_ready`=0 after 2 entries, `FIFO_DEPTH`=2); ALU writes x1 for 4 cycles; then x2 and x3 written in order; x4 accepted once space frees and written last.
- Load with rd=0 and `alu_rd`=0 with `alu_valid`=1 → no `we3` pulse ever; FIFO drains; `pend[0]` stays 0.
- `issue_valid` with rd=9 on the same edge that a load write to x9 commits → `pend[9]` remains 1.
- Fill the FIFO, then pulse `rst_n` low asynchronously between edges → `we3`=0, `pend`=0 and `mem_ready`=1 immediately; no stale write after release.
